// File: rtl/serial_mod_checker.sv
// serial_mod_checker: bit-serial MSB-first divisibility checker with a runtime divisor
module serial_mod_checker #(
  parameter int MAX_DIV = 16,
  parameter int MAX_BITS = 32,
  localparam int DW = $clog2(MAX_DIV + 1),
  localparam int RW = $clog2(MAX_DIV),
  localparam int CW = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] div_in,
  input  logic          valid,
  input  logic          x,
  input  logic          last,
  output logic          y,
  output logic [RW-1:0] rem,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] bit_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state, state_n;
  logic [DW-1:0] div, cur_d;
  logic [RW-1:0] cur_rem, rem_n;
  logic [DW:0] t;
  logic good, acc;
  always_comb begin
    good = div_in != '0 && div_in <= DW'(MAX_DIV);
    cur_d = start ? div_in : div;
    cur_rem = start ? '0 : rem;
    acc = valid && (start ? good : state == RUN);
    // 2*rem+x is just the residue with x shifted in; one subtract keeps it below D
    t = (DW+1)'({cur_rem, x});
    rem_n = RW'(t >= {1'b0, cur_d} ? t - {1'b0, cur_d} : t);
    state_n = acc && last ? IDLE : start ? (good ? RUN : ERR) : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= 1'b0;
      rem <= '0;
      done <= 1'b0;
      err <= 1'b0;
      bit_cnt <= '0;
      div <= DW'(1);
    end else begin
      done <= acc && last;
      if (start) begin
        err <= !good;
        if (good) div <= div_in;
      end
      if (acc) begin
        rem <= rem_n;
        y <= rem_n == '0;
        bit_cnt <= start ? CW'(1) : bit_cnt == CW'(MAX_BITS) ? bit_cnt : bit_cnt + 1'b1;
      end else if (start) begin
        rem <= '0;
        y <= 1'b0;
        bit_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_mod_checker.sv
// tb_serial_mod_checker: directed vector table, saturation sequence and random run against a modular-arithmetic model
module tb_serial_mod_checker;
  logic clk = 0, rst = 0, start = 0, valid = 0, x = 0, last = 0;
  logic [4:0] div_in = '0;
  logic y, done, err;
  logic [3:0] rem;
  logic [5:0] bit_cnt;
  int checks = 0, errors = 0;

  serial_mod_checker dut (
    .clk(clk), .rst(rst), .start(start), .div_in(div_in), .valid(valid), .x(x),
    .last(last), .y(y), .rem(rem), .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s;
    logic [4:0] dv;
    logic v, xb, l;
    logic ey;
    logic [3:0] erem;
    logic ed, ee;
    logic [5:0] ec;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, s, input int dv, input logic v, xb, l,
                     input logic ey, input int erem, input logic ed, ee, input int ec);
    vec_t t;
    t.r = r; t.s = s; t.dv = 5'(dv); t.v = v; t.xb = xb; t.l = l;
    t.ey = ey; t.erem = 4'(erem); t.ed = ed; t.ee = ee; t.ec = 6'(ec);
    vecs.push_back(t);
  endtask

  task automatic chk(input string n, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step(input logic r, s, input logic [4:0] dv, input logic v, xb, l);
    rst = r; start = s; div_in = dv; valid = v; x = xb; last = l;
    @(posedge clk);
    #1;
  endtask

  // reference: residue arithmetic on integers, frame state as plain flags
  int m_d, m_rem, m_cnt;
  bit m_y, m_done, m_err, m_run;
  task automatic model(input logic r, s, input logic [4:0] dv, input logic v, xb, l);
    if (r) begin
      m_d = 1; m_rem = 0; m_cnt = 0; m_y = 0; m_done = 0; m_err = 0; m_run = 0;
      return;
    end
    m_done = 0;
    if (s) begin
      m_err = !(dv >= 1 && dv <= 16);
      if (!m_err) m_d = int'(dv);
      m_run = !m_err;
      m_rem = 0; m_y = 0; m_cnt = 0;
    end
    if (v && m_run) begin
      m_rem = (2 * m_rem + int'(xb)) % m_d;
      m_y = m_rem == 0;
      m_cnt = m_cnt + 1 > 32 ? 32 : m_cnt + 1;
      if (l) begin m_run = 0; m_done = 1; end
    end
  endtask

  initial begin
    //   r s dv v x l | y rem done err cnt
    add(1,0, 0,0,0,0, 0,0,0,0,0);
    add(0,1, 3,0,0,0, 0,0,0,0,0);
    add(0,0, 0,1,1,0, 0,1,0,0,1);
    add(0,0, 0,1,1,0, 1,0,0,0,2);
    add(0,0, 0,1,0,1, 1,0,1,0,3);
    add(0,0, 0,0,0,0, 1,0,0,0,3);
    add(0,0, 0,1,1,0, 1,0,0,0,3);
    add(0,1, 2,0,0,0, 0,0,0,0,0);
    add(0,0, 0,1,1,0, 0,1,0,0,1);
    add(0,0, 0,1,0,0, 1,0,0,0,2);
    add(0,0, 0,1,1,1, 0,1,1,0,3);
    add(0,1,16,1,1,0, 0,1,0,0,1);
    add(0,0, 0,0,1,0, 0,1,0,0,1);
    add(0,0, 0,0,0,0, 0,1,0,0,1);
    add(0,0, 0,1,0,0, 0,2,0,0,2);
    add(0,0, 0,0,1,0, 0,2,0,0,2);
    add(0,0, 0,0,0,0, 0,2,0,0,2);
    add(0,0, 0,1,0,0, 0,4,0,0,3);
    add(0,0, 0,1,0,0, 0,8,0,0,4);
    add(0,0, 0,1,0,1, 1,0,1,0,5);
    add(0,1, 0,0,0,0, 0,0,0,1,0);
    add(0,0, 0,1,1,0, 0,0,0,1,0);
    add(0,0, 0,1,1,0, 0,0,0,1,0);
    add(0,0, 0,1,1,1, 0,0,0,1,0);
    add(0,1, 5,0,0,0, 0,0,0,0,0);
    add(0,0, 0,1,1,0, 0,1,0,0,1);
    add(0,0, 0,1,1,0, 0,3,0,0,2);
    add(0,0, 0,1,1,0, 0,2,0,0,3);
    add(0,1,17,0,0,0, 0,0,0,1,0);
    add(0,1, 7,0,0,0, 0,0,0,0,0);
    add(0,0, 0,1,1,0, 0,1,0,0,1);
    add(0,0, 0,1,0,0, 0,2,0,0,2);
    add(0,0, 0,1,0,0, 0,4,0,0,3);
    add(0,1, 3,1,1,0, 0,1,0,0,1);
    add(0,0, 0,1,0,0, 0,2,0,0,2);
    add(0,0, 0,0,0,1, 0,2,0,0,2);
    add(1,0, 0,1,1,0, 0,0,0,0,0);
    add(0,0, 0,1,1,0, 0,0,0,0,0);
    add(0,0, 0,1,0,0, 0,0,0,0,0);
    add(0,1, 1,1,1,0, 1,0,0,0,1);
    add(0,0, 0,1,0,1, 1,0,1,0,2);
    add(0,0, 0,0,0,0, 1,0,0,0,2);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].dv, vecs[i].v, vecs[i].xb, vecs[i].l);
      chk($sformatf("v%0d.y", i), 32'(y), 32'(vecs[i].ey));
      chk($sformatf("v%0d.rem", i), 32'(rem), 32'(vecs[i].erem));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].ed));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].ee));
      chk($sformatf("v%0d.cnt", i), 32'(bit_cnt), 32'(vecs[i].ec));
    end
    // 40 ones: 2^40-1 is divisible by 3, count pins at 32
    step(0, 1, 5'd3, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 5'd0, 1, 1, i == 39);
    chk("sat.cnt", 32'(bit_cnt), 32);
    chk("sat.rem", 32'(rem), 0);
    chk("sat.y", 32'(y), 1);
    chk("sat.done", 32'(done), 1);
    // random traffic against the model
    step(1, 0, 5'd0, 0, 0, 0);
    model(1, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic r, s, v, xb, l;
      logic [4:0] dv;
      r = $urandom_range(0, 149) == 0;
      s = $urandom_range(0, 11) == 0;
      dv = 5'($urandom_range(0, 18));
      v = $urandom_range(0, 9) < 6;
      xb = 1'($urandom);
      l = $urandom_range(0, 14) == 0;
      step(r, s, dv, v, xb, l);
      model(r, s, dv, v, xb, l);
      chk($sformatf("r%0d.y", i), 32'(y), 32'(m_y));
      chk($sformatf("r%0d.rem", i), 32'(rem), 32'(m_rem));
      chk($sformatf("r%0d.done", i), 32'(done), 32'(m_done));
      chk($sformatf("r%0d.err", i), 32'(err), 32'(m_err));
      chk($sformatf("r%0d.cnt", i), 32'(bit_cnt), 32'(m_cnt));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
